// File: rtl/axis_adc_packer.sv
// axis_adc_packer
// Packs pairs of 32-bit ADC samples (channel A [15:0], channel B [31:16])
// into 64-bit AXI4-Stream words. The older sample of a pair occupies the
// low half. A 2-entry output buffer absorbs short downstream stalls; words
// that find the buffer full are dropped and counted (saturating).
module axis_adc_packer #(
    parameter int AXIS_TDATA_WIDTH_IN = 32,
    parameter int AXIS_TDATA_WIDTH    = 64,
    parameter int CNTR_WIDTH          = 32
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           cfg_enable,
    input  logic [AXIS_TDATA_WIDTH_IN-1:0] s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0]    m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [CNTR_WIDTH-1:0]          sts_words,
    output logic [CNTR_WIDTH-1:0]          sts_dropped
);

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_t;

    phase_t                         phase_q;
    phase_t                         phase_d;
    logic                           push_req;
    logic [AXIS_TDATA_WIDTH_IN-1:0] hold_q;
    logic [AXIS_TDATA_WIDTH-1:0]    word;
    logic [AXIS_TDATA_WIDTH-1:0]    head_q;
    logic [AXIS_TDATA_WIDTH-1:0]    tail_q;
    logic [1:0]                     count_q;
    logic                           accept;
    logic                           pop;
    logic                           push_ok;
    logic [CNTR_WIDTH-1:0]          words_q;
    logic [CNTR_WIDTH-1:0]          dropped_q;

    assign accept  = cfg_enable & s_axis_tvalid;
    assign word    = {s_axis_tdata, hold_q};
    assign pop     = (count_q != 2'd0) & m_axis_tready;
    assign push_ok = push_req & ((count_q != 2'd2) | pop);

    // Phase register
    always_ff @(posedge aclk) begin
        if (areset) begin
            phase_q <= PH_LO;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase sequencing: low half first, high half completes a word
    always_comb begin
        phase_d  = phase_q;
        push_req = 1'b0;
        if (!cfg_enable) begin
            phase_d = PH_LO;
        end else if (s_axis_tvalid) begin
            case (phase_q)
                PH_LO: phase_d = PH_HI;
                PH_HI: begin
                    phase_d  = PH_LO;
                    push_req = 1'b1;
                end
                default: phase_d = PH_LO;
            endcase
        end
    end

    // Holding register for the low-half sample
    always_ff @(posedge aclk) begin
        if (areset) begin
            hold_q <= '0;
        end else if (accept && (phase_q == PH_LO)) begin
            hold_q <= s_axis_tdata;
        end
    end

    // Two-entry output buffer; head_q is always the oldest word
    always_ff @(posedge aclk) begin
        if (areset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push_ok, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= word;
                    end else begin
                        tail_q <= word;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: the new word lands directly behind
                    // whatever becomes the head after the pop.
                    if (count_q == 2'd1) begin
                        head_q <= word;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= word;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status counters: accepted words wrap, dropped words saturate
    always_ff @(posedge aclk) begin
        if (areset) begin
            words_q   <= '0;
            dropped_q <= '0;
        end else begin
            if (push_ok) begin
                words_q <= words_q + CNTR_WIDTH'(1);
            end
            if (push_req && !push_ok && (dropped_q != '1)) begin
                dropped_q <= dropped_q + CNTR_WIDTH'(1);
            end
        end
    end

    assign m_axis_tdata  = head_q;
    assign m_axis_tvalid = (count_q != 2'd0);
    assign sts_words     = words_q;
    assign sts_dropped   = dropped_q;

endmodule

// File: tb/tb_axis_adc_packer.sv
// Self-checking bench for axis_adc_packer: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_axis_adc_packer;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cfg_enable;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] sts_words;
    logic [31:0] sts_dropped;

    always #5 aclk = ~aclk;

    axis_adc_packer #(
        .AXIS_TDATA_WIDTH_IN(32),
        .AXIS_TDATA_WIDTH   (64),
        .CNTR_WIDTH         (32)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .cfg_enable   (cfg_enable),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .sts_words    (sts_words),
        .sts_dropped  (sts_dropped)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending words, pending-half flag, counters
    logic [63:0] mq[$];
    bit          m_pend;
    logic [31:0] m_held;
    logic [31:0] m_words;
    logic [31:0] m_drop;

    always @(posedge aclk) begin
        if (areset) begin
            mq.delete();
            m_pend  = 1'b0;
            m_held  = '0;
            m_words = '0;
            m_drop  = '0;
        end else begin
            if (mq.size() > 0 && m_axis_tready) void'(mq.pop_front());
            if (!cfg_enable) begin
                m_pend = 1'b0;
            end else if (s_axis_tvalid) begin
                if (!m_pend) begin
                    m_held = s_axis_tdata;
                    m_pend = 1'b1;
                end else begin
                    m_pend = 1'b0;
                    if (mq.size() < 2) begin
                        mq.push_back({s_axis_tdata, m_held});
                        m_words = m_words + 32'd1;
                    end else if (m_drop != 32'hFFFF_FFFF) begin
                        m_drop = m_drop + 32'd1;
                    end
                end
            end
        end
    end

    // Words actually handed off downstream
    logic [63:0] olog[$];
    always @(posedge aclk) begin
        if (!areset && m_axis_tvalid === 1'b1 && m_axis_tready) olog.push_back(m_axis_tdata);
    end

    // Per-cycle comparison against the model
    always @(negedge aclk) begin
        if (check_en) begin
            chk("cyc_valid", 64'(m_axis_tvalid), 64'(mq.size() != 0));
            if (mq.size() != 0) chk("cyc_data", m_axis_tdata, mq[0]);
            chk("cyc_words", 64'(sts_words), 64'(m_words));
            chk("cyc_dropped", 64'(sts_dropped), 64'(m_drop));
        end
    end

    function automatic logic [31:0] samp(input int i);
        return {16'(i) + 16'h1000, 16'(i)};
    endfunction

    task automatic step(input logic en, input logic v, input logic [31:0] d, input logic rdy);
        cfg_enable    = en;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        m_axis_tready = rdy;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        areset = 1'b0;
        olog.delete();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    logic [63:0] lg;

    initial begin
        areset        = 1'b1;
        cfg_enable    = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        @(posedge aclk);
        @(posedge aclk);
        #1;
        areset   = 1'b0;
        check_en = 1'b1;
        chk("rst_valid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_data", m_axis_tdata, 64'd0);
        chk("rst_words", 64'(sts_words), 64'd0);
        chk("rst_dropped", 64'(sts_dropped), 64'd0);

        // Basic pack
        do_reset();
        step(1'b1, 1'b1, 32'h0001_0000, 1'b1);
        step(1'b1, 1'b1, 32'h0003_0002, 1'b1);
        chk("lat_valid", 64'(m_axis_tvalid), 64'd1);
        chk("lat_data1", m_axis_tdata, 64'h0003_0002_0001_0000);
        step(1'b1, 1'b1, 32'h0005_0004, 1'b1);
        step(1'b1, 1'b1, 32'h0007_0006, 1'b1);
        chk("lat_data2", m_axis_tdata, 64'h0007_0006_0005_0004);
        drain(2);
        chk("basic_n", 64'(olog.size()), 64'd2);
        lg = (olog.size() > 0) ? olog[0] : 64'd0;
        chk("basic_w0", lg, 64'h0003_0002_0001_0000);
        lg = (olog.size() > 1) ? olog[1] : 64'd0;
        chk("basic_w1", lg, 64'h0007_0006_0005_0004);
        chk("basic_words", 64'(sts_words), 64'd2);
        chk("basic_dropped", 64'(sts_dropped), 64'd0);

        // Three-cycle stall with continuous input
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, samp(i), !(i >= 6 && i < 9));
        drain(4);
        chk("stall_n", 64'(olog.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            lg = (olog.size() > k) ? olog[k] : 64'd0;
            chk("stall_order", lg, {samp(2 * k + 1), samp(2 * k)});
        end
        chk("stall_dropped", 64'(sts_dropped), 64'd0);
        chk("stall_words", 64'(sts_words), 64'd8);

        // Overflow with tready held low
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, samp(i), 1'b0);
        chk("ovf_words", 64'(sts_words), 64'd2);
        chk("ovf_dropped", 64'(sts_dropped), 64'd2);
        chk("ovf_valid", 64'(m_axis_tvalid), 64'd1);
        drain(4);
        chk("ovf_n", 64'(olog.size()), 64'd2);
        lg = (olog.size() > 0) ? olog[0] : 64'd0;
        chk("ovf_w0", lg, {samp(1), samp(0)});
        lg = (olog.size() > 1) ? olog[1] : 64'd0;
        chk("ovf_w1", lg, {samp(3), samp(2)});

        // Push while full, with a pop on the same edge
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, samp(i), 1'b0);
        step(1'b1, 1'b1, samp(4), 1'b0);
        step(1'b1, 1'b1, samp(5), 1'b1);
        chk("full_words", 64'(sts_words), 64'd3);
        chk("full_dropped", 64'(sts_dropped), 64'd0);
        chk("full_head", m_axis_tdata, {samp(3), samp(2)});
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("full_valid", 64'(m_axis_tvalid), 64'd1);
        drain(4);
        chk("full_n", 64'(olog.size()), 64'd3);
        lg = (olog.size() > 2) ? olog[2] : 64'd0;
        chk("full_w2", lg, {samp(5), samp(4)});

        // Enable dropped mid-pair
        do_reset();
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        step(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
        step(1'b1, 1'b1, 32'h1111_2222, 1'b1);
        step(1'b1, 1'b1, 32'h3333_4444, 1'b1);
        drain(2);
        chk("en_n", 64'(olog.size()), 64'd1);
        lg = (olog.size() > 0) ? olog[0] : 64'd0;
        chk("en_word", lg, 64'h3333_4444_1111_2222);
        chk("en_dropped", 64'(sts_dropped), 64'd0);
        chk("en_words", 64'(sts_words), 64'd1);

        // Reset with two buffered words and a half-filled pair
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, samp(i), 1'b0);
        chk("mr_pre_valid", 64'(m_axis_tvalid), 64'd1);
        areset = 1'b1;
        step(1'b1, 1'b1, 32'h5555_6666, 1'b0);
        areset = 1'b0;
        chk("mr_valid", 64'(m_axis_tvalid), 64'd0);
        chk("mr_data", m_axis_tdata, 64'd0);
        chk("mr_words", 64'(sts_words), 64'd0);
        chk("mr_dropped", 64'(sts_dropped), 64'd0);
        step(1'b1, 1'b1, 32'h7777_8888, 1'b1);
        step(1'b1, 1'b1, 32'h9999_AAAA, 1'b1);
        chk("mr_next_valid", 64'(m_axis_tvalid), 64'd1);
        chk("mr_next_data", m_axis_tdata, 64'h9999_AAAA_7777_8888);
        drain(3);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
